// File: rtl/seq_detector_scheduler_pkg.sv
// Shared definitions for the sequence-detector scheduler: FSM encoding,
// default widths and requester identifiers.
package seq_detector_scheduler_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Plain vector encodings of the states for logic-typed state registers.
  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_CLR   = CLR;
  localparam logic [2:0] ST_SHIFT = SHIFT;
  localparam logic [2:0] ST_DRAIN = DRAIN;
  localparam logic [2:0] ST_RESP  = RESP;

endpackage

// File: rtl/seq_detector_scheduler_if.sv
// Requester handshake and response bus of the scheduler. The requester side
// uses the master modport, the scheduler uses the slave modport.
interface seq_detector_scheduler_if
  import seq_detector_scheduler_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic              req0_valid;
  logic [WORD_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [WORD_W-1:0] req1_data;
  logic              req1_ready;
  logic              resp_valid;
  logic              resp_id;
  logic [CNT_W-1:0]  resp_count;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_count
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_count
  );

endinterface

// File: rtl/seq_detector_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter. The grant is combinational from the requests
// and the last winner; last_grant only moves when the owner accepts a grant.
module rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  // One-hot grant: a lone requester always wins, a tie goes to the one that did not win last.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Remember the latest winner; reset favours requester 0 for the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant[1];
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/seq_detector_scheduler.sv
// Time-shares one serial sequence detector between two requesters: accepts a
// word, clears the detector, shifts the word in MSB-first, counts y=1 samples
// (saturating) and returns the count tagged with the requester id.
module seq_detector_scheduler
  import seq_detector_scheduler_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  seq_detector_scheduler_if.slave     bus,
  output logic                        det_x,
  output logic                        det_rst,
  input  logic                        det_y,
  output logic                        busy
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  logic [2:0]        state;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bitcnt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              id;
  logic              resp_valid;
  logic              resp_id;
  logic [CNT_W-1:0]  resp_count;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              fire;
  logic              sample;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  assign req  = {bus.req1_valid, bus.req0_valid};
  assign fire = (state == ST_IDLE) && ((req & grant) != 2'b00);

  rr_arbiter_2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .update (fire),
    .grant  (grant)
  );

  // Ready is only offered while idle, to the requester the arbiter selected.
  always_comb begin
    bus.req0_ready = (state == ST_IDLE) && grant[0];
    bus.req1_ready = (state == ST_IDLE) && grant[1];
  end

  // det_y lags det_x by one cycle, so the first SHIFT cycle and CLR carry no sample; DRAIN holds the last one.
  always_comb begin
    sample = ((state == ST_SHIFT) && (bitcnt != '0)) || (state == ST_DRAIN);
    if (sample && det_y) begin
      count_next = sat_inc(count);
    end else begin
      count_next = count;
    end
  end

  // Main sequencer: accept, clear, shift WORD_W bits, drain the last sample, respond.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      count      <= '0;
      id         <= REQ0;
      det_x      <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_count <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          det_x <= 1'b0;
          if (fire) begin
            shreg  <= grant[1] ? bus.req1_data : bus.req0_data;
            id     <= grant[1] ? REQ1 : REQ0;
            count  <= '0;
            bitcnt <= '0;
            state  <= ST_CLR;
          end
        end
        ST_CLR: begin
          det_x  <= shreg[WORD_W-1];
          shreg  <= {shreg[WORD_W-2:0], 1'b0};
          bitcnt <= '0;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          count <= count_next;
          if (bitcnt == LAST_BIT) begin
            det_x <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            det_x  <= shreg[WORD_W-1];
            shreg  <= {shreg[WORD_W-2:0], 1'b0};
            bitcnt <= bitcnt + BC_W'(1);
          end
        end
        ST_DRAIN: begin
          det_x      <= 1'b0;
          count      <= count_next;
          resp_count <= count_next;
          resp_id    <= id;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          det_x <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          det_x <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign det_rst        = reset || (state == ST_CLR);
  assign busy           = (state != ST_IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_id    = resp_id;
  assign bus.resp_count = resp_count;

endmodule

// File: tb/tb_seq_detector_scheduler.sv
// Directed bench for seq_detector_scheduler: a delay-stub detector (count =
// popcount), a real overlapping "101" detector, and a CNT_W=3 instance fed
// y=1 constantly to exercise saturation.
module tb_seq_detector_scheduler;

  logic clock;
  logic reset;
  logic sel_real;

  seq_detector_scheduler_if #(.WORD_W(8), .CNT_W(4)) bus_main ();
  seq_detector_scheduler_if #(.WORD_W(8), .CNT_W(3)) bus_sat ();

  logic det_x, det_rst, det_y, busy;
  logic det_x2, det_rst2, busy2;
  logic stub_y, real_y;
  logic [2:0] hist;

  int checks = 0;
  int errors = 0;

  seq_detector_scheduler #(.WORD_W(8), .CNT_W(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_main),
    .det_x   (det_x),
    .det_rst (det_rst),
    .det_y   (det_y),
    .busy    (busy)
  );

  seq_detector_scheduler #(.WORD_W(8), .CNT_W(3)) dut_sat (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_sat),
    .det_x   (det_x2),
    .det_rst (det_rst2),
    .det_y   (1'b1),
    .busy    (busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stub detector: y is x delayed by one clock.
  always_ff @(posedge clock) begin
    if (det_rst) stub_y <= 1'b0;
    else         stub_y <= det_x;
  end

  // Real detector: registered Moore output for overlapping pattern 101.
  always_ff @(posedge clock) begin
    if (det_rst) begin
      hist   <= 3'b000;
      real_y <= 1'b0;
    end else begin
      hist   <= {hist[1:0], det_x};
      real_y <= ({hist[1:0], det_x} == 3'b101);
    end
  end

  assign det_y = sel_real ? real_y : stub_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [3:0] golden_101(input logic [7:0] w);
    logic [2:0] h;
    logic [3:0] c;
    h = 3'b000;
    c = 4'd0;
    for (int k = 0; k < 8; k++) begin
      h = {h[1:0], w[7-k]};
      if (h == 3'b101) c = c + 4'd1;
    end
    return c;
  endfunction

  // Presents w on requester id in the current idle cycle and follows it to its response.
  task automatic do_word(input logic id, input logic [7:0] w, input logic [3:0] cnt,
                         input bit hold, input string tag);
    if (id == 1'b0) begin
      bus_main.req0_valid = 1'b1;
      bus_main.req0_data  = w;
    end else begin
      bus_main.req1_valid = 1'b1;
      bus_main.req1_data  = w;
    end
    #1;
    check({tag, "_ready_own"}, id ? bus_main.req1_ready : bus_main.req0_ready, 1);
    check({tag, "_ready_other"}, id ? bus_main.req0_ready : bus_main.req1_ready, 0);
    tick();
    if (!hold) begin
      if (id == 1'b0) begin
        bus_main.req0_valid = 1'b0;
        bus_main.req0_data  = ~w;
      end else begin
        bus_main.req1_valid = 1'b0;
        bus_main.req1_data  = ~w;
      end
    end
    #1;
    check({tag, "_clr_det_rst"}, det_rst, 1);
    check({tag, "_clr_busy"}, busy, 1);
    check({tag, "_clr_ready"}, bus_main.req0_ready | bus_main.req1_ready, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("%s_det_x_k%0d", tag, k), det_x, w[7-k]);
    end
    tick();
    check({tag, "_drain_x"}, det_x, 0);
    check({tag, "_drain_resp"}, bus_main.resp_valid, 0);
    tick();
    check({tag, "_resp_valid"}, bus_main.resp_valid, 1);
    check({tag, "_resp_id"}, bus_main.resp_id, id);
    check({tag, "_resp_count"}, bus_main.resp_count, cnt);
  endtask

  initial begin
    reset    = 1'b1;
    sel_real = 1'b0;
    bus_main.req0_valid = 1'b0; bus_main.req0_data = 8'h00;
    bus_main.req1_valid = 1'b0; bus_main.req1_data = 8'h00;
    bus_sat.req0_valid  = 1'b0; bus_sat.req0_data  = 8'h00;
    bus_sat.req1_valid  = 1'b0; bus_sat.req1_data  = 8'h00;

    // 1: reset held three cycles, then idle with no requests
    tick(); tick(); tick();
    check("rst_det_rst", det_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", bus_main.resp_valid, 0);
    check("rst_resp_id", bus_main.resp_id, 0);
    check("rst_resp_count", bus_main.resp_count, 0);
    check("rst_det_x", det_x, 0);
    check("rst_det_rst2", det_rst2, 1);
    reset = 1'b0;
    #1;
    check("idle_det_rst", det_rst, 0);
    check("idle_ready", {bus_main.req1_ready, bus_main.req0_ready}, 0);
    tick();
    check("idle_busy", busy, 0);
    check("idle_resp_valid", bus_main.resp_valid, 0);

    // 2: single word from requester 0, data scrambled after acceptance
    do_word(1'b0, 8'b1011_0010, 4'd4, 1'b0, "s2");
    tick();
    check("s2_after_valid", bus_main.resp_valid, 0);
    check("s2_after_busy", busy, 0);
    check("s2_hold_count", bus_main.resp_count, 4);

    // 3: both requesting continuously after a fresh reset -> 0 then 1 then 0
    reset = 1'b1;
    tick();
    check("s3_rst_det_rst", det_rst, 1);
    reset = 1'b0;
    tick();
    bus_main.req1_valid = 1'b1;
    bus_main.req1_data  = 8'h01;
    do_word(1'b0, 8'hFF, 4'd8, 1'b1, "s3a");
    tick();
    do_word(1'b1, 8'h01, 4'd1, 1'b1, "s3b");
    tick();
    check("s3_alt_ready0", bus_main.req0_ready, 1);
    check("s3_alt_ready1", bus_main.req1_ready, 0);
    bus_main.req0_valid = 1'b0;
    bus_main.req1_valid = 1'b0;
    #1;
    tick();
    check("s3_dropped_busy", busy, 0);

    // 4: reset at SHIFT k=3 of a requester-1 word
    bus_main.req1_valid = 1'b1;
    bus_main.req1_data  = 8'hC3;
    #1;
    check("s4_ready1", bus_main.req1_ready, 1);
    tick();
    bus_main.req1_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("s4_k3_det_x", det_x, 0);
    check("s4_k3_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("s4_rst_det_rst", det_rst, 1);
    check("s4_rst_busy", busy, 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("s4_no_resp_%0d", i), bus_main.resp_valid, 0);
    end
    check("s4_count_cleared", bus_main.resp_count, 0);
    bus_main.req0_valid = 1'b1;
    bus_main.req1_valid = 1'b1;
    #1;
    check("s4_next_ready0", bus_main.req0_ready, 1);
    check("s4_next_ready1", bus_main.req1_ready, 0);
    bus_main.req0_valid = 1'b0;
    bus_main.req1_valid = 1'b0;
    tick();

    // 5: CNT_W=3 instance with y stuck at 1 saturates at 7
    bus_sat.req0_valid = 1'b1;
    bus_sat.req0_data  = 8'hA5;
    #1;
    check("s5_ready0", bus_sat.req0_ready, 1);
    tick();
    bus_sat.req0_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("s5_resp_valid", bus_sat.resp_valid, 1);
    check("s5_resp_count", bus_sat.resp_count, 7);
    check("s5_busy", busy2, 1);

    // 6: real 101 detector, word 0110_1101
    sel_real = 1'b1;
    tick();
    do_word(1'b0, 8'b0110_1101, golden_101(8'b0110_1101), 1'b0, "s6");
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("s6_single_resp_%0d", i), bus_main.resp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_scheduler.md
Name: seq_detector_scheduler

Overview:
- Shares one serial sequence-detector FSM (single-bit x in, single-bit y out, registered) between two requesters.
- Each requester hands over a parallel word. The block picks one requester round-robin, clears the detector, shifts the word in MSB-first, counts the cycles where y=1, and returns the count tagged with the requester id.
- Sits between the requester logic and the detector instance; it is the only driver of the detector's x input and clear.

Parameters:
- WORD_W, 8, bits per word shifted into the detector (range 2..32).
- CNT_W, 4, width of the detection count; must satisfy 2^CNT_W-1 >= WORD_W.

Ports:
- clock  in  1  rising-edge clock, shared with the detector.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WORD_W  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WORD_W  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- det_x  out  1  serial bit to the detector x input.
- det_rst  out  1  active-high clear to the detector.
- det_y  in  1  detector output.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  1  requester the response belongs to.
- resp_count  out  CNT_W  number of y=1 samples for the word.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async):
  - State goes to IDLE; last_grant=1, so requester 0 wins first.
  - Bit counter, shift register and count go to 0.
  - resp_valid=0, resp_id=0, resp_count=0, det_x=0, busy=0.
  - det_rst=1 while reset is high (det_rst = reset OR state==CLR).
- States and transitions: IDLE -> CLR -> SHIFT -> DRAIN -> RESP -> IDLE.
- IDLE:
  - If any valid is high, grant round-robin: with both valid, grant the one not equal to last_grant.
  - reqN_ready is combinational: high only in IDLE for the granted N.
  - The handshake is valid AND ready. On it, latch data into the shift register, latch id, update last_grant, clear count, go to CLR.
  - ready is never high outside IDLE.
- CLR (1 cycle): det_rst=1, det_x=0.
- SHIFT (WORD_W cycles, index k=0..WORD_W-1):
  - det_x = word bit WORD_W-1-k, registered from the shift register.
  - In cycles k>=1, sample det_y; it reflects bit k-1.
- DRAIN (1 cycle): det_x=0; sample det_y for the last bit. This gives exactly WORD_W samples in total.
- Counting: count increments when a sampled det_y=1, saturating at 2^CNT_W-1.
- RESP (1 cycle): resp_valid=1; resp_id and resp_count hold the values for this word. resp_id and resp_count keep their values until the next RESP.
- Latency:
  - Handshake at cycle t. CLR at t+1, SHIFT at t+2..t+1+WORD_W, DRAIN at t+2+WORD_W, RESP at t+3+WORD_W.
  - Earliest next handshake is t+4+WORD_W (12 cycles per word for WORD_W=8).
- Boundary conditions:
  - Both valid continuously: grants strictly alternate 0,1,0,1.
  - Only one valid: it is granted every slot regardless of last_grant.
  - Valid dropped before its grant: nothing is latched.
  - Data changes after the handshake: ignored.
  - Reset mid-word: abort; no resp_valid for that word; the word is lost; the requester must re-present it.
  - det_y during CLR and IDLE: ignored.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CLR, SHIFT, DRAIN, RESP};
  - WORD_W and CNT_W defaults;
  - REQ0/REQ1 id constants.
- Sub-module rr_arbiter_2:
  - two requests in, one-hot grant out;
  - update strobe;
  - last_grant register with the same clock and async active-high reset.

Test Plan:
- Detector stub for scenarios 1-4: y = x delayed one clock, so count = popcount.
- 1. Reset held 3 cycles, released, no valid -> all outputs 0, det_rst=1 only during reset, busy=0.
- 2. req0 word 8'b1011_0010 -> req0_ready at t; det_x sequence 1,0,1,1,0,0,1,0 on t+2..t+9; resp_valid at t+11 with id=0, count=4.
- 3. req0 and req1 valid together, words 8'hFF and 8'h01 -> req0 granted first with count=8; req1 handshake 12 cycles later with count=1; responses alternate ids.
- 4. Reset asserted at SHIFT k=3 of a req1 word, released 2 cycles later -> no resp_valid; next grant goes to req0; det_rst high during reset.
- 5. Detector stub driving y=1 constantly, CNT_W=3 -> count saturates at 7, not 0.
- 6. Real sequence-detector instance with word 8'b0110_1101 -> resp_count equals the golden-model count of y=1 samples, one response only.
